alu_issue_ctrl: RTL and testbench

// - Execute-stage issue controller between decode and the ALU operand mux; owns the ID/EX boundary.
// - Accepts decoded instructions on a valid/ready handshake and buffers them in a 2-entry skid buffer.
// - Derives alu_src[2:0] and alu_op from opcode/funct, and presents registered operands to the operand mux + ALU.

---
 rtl/my_pkg.sv | 64 ++++++
 rtl/alu_src_dec.sv | 51 +++++
 rtl/alu_issue_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/my_pkg.sv
// Shared types and constants for the execute-stage issue controller (alu_issue_ctrl).
// Optional writeback bypass is enabled by defining ALU_ISSUE_FWD_EN.
package my_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    // alu_src bit0 selects pc as data1; bits [2:1] pick data2: 00 rs2, 01 imm, 1x constant 4.
    localparam logic [2:0] ALU_SRC_RS2    = 3'b000;
    localparam logic [2:0] ALU_SRC_IMM    = 3'b010;
    localparam logic [2:0] ALU_SRC_PC_IMM = 3'b011;
    localparam logic [2:0] ALU_SRC_PC_4   = 3'b101;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } issue_state_e;

    // Control half of a buffered instruction; operand data is sized by module parameters.
    typedef struct packed {
        logic [2:0] alu_src;
        alu_op_e    alu_op;
        logic       illegal;
    } issue_entry_t;

    function automatic alu_op_e funct3_op(input logic [2:0] f3, input logic b5,
                                          input logic allow_sub);
        case (f3)
            3'b000:  return (allow_sub && b5) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return b5 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_src_dec.sv
// Combinational decode of opcode/funct into operand-mux select, ALU operation and illegal flag.
// Used by alu_issue_ctrl at capture time; independent of ALU_ISSUE_FWD_EN.
module alu_src_dec
    import my_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [2:0] alu_src,
    output alu_op_e    alu_op,
    output logic       illegal,
    output logic       zero_rs1
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
        alu_src  = ALU_SRC_RS2;
        alu_op   = ALU_ADD;
        illegal  = 1'b0;
        zero_rs1 = 1'b0;
        case (opcode)
            OPC_OP: begin
                alu_op = funct3_op(funct3, funct7b5, 1'b1);
            end
            OPC_OP_IMM: begin
                alu_src = ALU_SRC_IMM;
                alu_op  = funct3_op(funct3, funct7b5, 1'b0);
            end
            OPC_LOAD, OPC_STORE: begin
                alu_src = ALU_SRC_IMM;
            end
            OPC_BRANCH: begin
                alu_op = ALU_SUB;
            end
            OPC_LUI: begin
                alu_src  = ALU_SRC_IMM;
                zero_rs1 = 1'b1;
            end
            OPC_AUIPC: begin
                alu_src = ALU_SRC_PC_IMM;
            end
            OPC_JAL, OPC_JALR: begin
                alu_src = ALU_SRC_PC_4;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ID/EX issue controller: 2-entry skid buffer with decode of alu_src/alu_op toward the ALU.
// Define ALU_ISSUE_FWD_EN to add the writeback bypass onto captured and buffered operands.
module alu_issue_ctrl
    import my_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [6:0]            id_opcode,
    input  logic [2:0]            id_funct3,
    input  logic                  id_funct7b5,
    input  logic [ADDR_WIDTH-1:0] id_pc,
    input  logic [DATA_WIDTH-1:0] id_rs1,
    input  logic [DATA_WIDTH-1:0] id_rs2,
    input  logic [DATA_WIDTH-1:0] id_imm,
`ifdef ALU_ISSUE_FWD_EN
    input  logic [4:0]            id_rs1_addr,
    input  logic [4:0]            id_rs2_addr,
    input  logic                  fwd_valid,
    input  logic [4:0]            fwd_rd,
    input  logic [DATA_WIDTH-1:0] fwd_data,
`endif
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [2:0]            ex_alu_src,
    output logic [3:0]            ex_alu_op,
    output logic [ADDR_WIDTH-1:0] ex_pc,
    output logic [DATA_WIDTH-1:0] ex_rs1,
    output logic [DATA_WIDTH-1:0] ex_rs2,
    output logic [DATA_WIDTH-1:0] ex_imm,
    output logic                  ex_illegal
);

    localparam int DEPTH = 2;

    issue_state_e          state_q, state_d;
    logic                  id_ready_q, id_ready_d;
    issue_entry_t          ctrl_q [DEPTH];
    issue_entry_t          ctrl_d [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_q   [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_d   [DEPTH];
    logic [DATA_WIDTH-1:0] rs1_q  [DEPTH];
    logic [DATA_WIDTH-1:0] rs1_d  [DEPTH];
    logic [DATA_WIDTH-1:0] rs2_q  [DEPTH];
    logic [DATA_WIDTH-1:0] rs2_d  [DEPTH];
    logic [DATA_WIDTH-1:0] imm_q  [DEPTH];
    logic [DATA_WIDTH-1:0] imm_d  [DEPTH];
    logic [DATA_WIDTH-1:0] hold_rs1 [DEPTH];
    logic [DATA_WIDTH-1:0] hold_rs2 [DEPTH];

    logic [2:0]            dec_src;
    alu_op_e               dec_op;
    logic                  dec_illegal;
    logic                  dec_zero_rs1;
    issue_entry_t          new_ctrl;
    logic [DATA_WIDTH-1:0] new_rs1;
    logic [DATA_WIDTH-1:0] new_rs2;
    logic                  acc;
    logic                  dep;
    logic [DEPTH-1:0]      load_new;
    logic                  shift;

    alu_src_dec u_dec (
        .opcode   (id_opcode),
        .funct3   (id_funct3),
        .funct7b5 (id_funct7b5),
        .alu_src  (dec_src),
        .alu_op   (dec_op),
        .illegal  (dec_illegal),
        .zero_rs1 (dec_zero_rs1)
    );

    assign ex_valid = (state_q != ST_EMPTY);
    assign id_ready = id_ready_q;
    assign acc      = id_valid & id_ready_q;
    assign dep      = ex_valid & ex_ready;

    always_comb begin
        new_ctrl.alu_src = dec_src;
        new_ctrl.alu_op  = dec_op;
        new_ctrl.illegal = dec_illegal;
    end

`ifdef ALU_ISSUE_FWD_EN
    logic [4:0] rs1_addr_q [DEPTH];
    logic [4:0] rs1_addr_d [DEPTH];
    logic [4:0] rs2_addr_q [DEPTH];
    logic [4:0] rs2_addr_d [DEPTH];
    logic [4:0] new_rs1_addr;

    function automatic logic [DATA_WIDTH-1:0] fwd_pick(input logic [DATA_WIDTH-1:0] val,
                                                       input logic [4:0] addr);
        return (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == addr)) ? fwd_data : val;
    endfunction

    // LUI stores rs1 index 0 so the bypass can never overwrite its zero operand.
    always_comb begin
        new_rs1_addr = dec_zero_rs1 ? 5'd0 : id_rs1_addr;
        new_rs1      = dec_zero_rs1 ? '0 : fwd_pick(id_rs1, id_rs1_addr);
        new_rs2      = fwd_pick(id_rs2, id_rs2_addr);
        for (int i = 0; i < DEPTH; i++) begin
            hold_rs1[i] = fwd_pick(rs1_q[i], rs1_addr_q[i]);
            hold_rs2[i] = fwd_pick(rs2_q[i], rs2_addr_q[i]);
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rs1_addr_d[i] = rs1_addr_q[i];
            rs2_addr_d[i] = rs2_addr_q[i];
        end
        if (shift) begin
            rs1_addr_d[0] = rs1_addr_q[1];
            rs2_addr_d[0] = rs2_addr_q[1];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (load_new[i]) begin
                rs1_addr_d[i] = new_rs1_addr;
                rs2_addr_d[i] = id_rs2_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rs1_addr_q[i] <= 5'd0;
                rs2_addr_q[i] <= 5'd0;
            end
        end else begin
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
        end
    end
`else
    always_comb begin
        new_rs1 = dec_zero_rs1 ? '0 : id_rs1;
        new_rs2 = id_rs2;
        for (int i = 0; i < DEPTH; i++) begin
            hold_rs1[i] = rs1_q[i];
            hold_rs2[i] = rs2_q[i];
        end
    end
`endif

    // Slot 0 is always the head; slot 1 only fills while the head is stalled.
    always_comb begin
        state_d  = state_q;
        load_new = '0;
        shift    = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    load_new[0] = 1'b1;
                    state_d     = ST_ONE;
                end
            end
            ST_ONE: begin
                if (acc && dep) begin
                    load_new[0] = 1'b1;
                end else if (acc) begin
                    load_new[1] = 1'b1;
                    state_d     = ST_TWO;
                end else if (dep) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (dep) begin
                    shift   = 1'b1;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
        end
        id_ready_d = (state_d != ST_TWO);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ctrl_d[i] = ctrl_q[i];
            pc_d[i]   = pc_q[i];
            rs1_d[i]  = hold_rs1[i];
            rs2_d[i]  = hold_rs2[i];
            imm_d[i]  = imm_q[i];
        end
        if (shift) begin
            ctrl_d[0] = ctrl_q[1];
            pc_d[0]   = pc_q[1];
            rs1_d[0]  = hold_rs1[1];
            rs2_d[0]  = hold_rs2[1];
            imm_d[0]  = imm_q[1];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (load_new[i]) begin
                ctrl_d[i] = new_ctrl;
                pc_d[i]   = id_pc;
                rs1_d[i]  = new_rs1;
                rs2_d[i]  = new_rs2;
                imm_d[i]  = id_imm;
            end
        end
    end

    // NOTE: the entry storage is reset too, because the ex_* outputs read it directly and must be 0 in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            id_ready_q <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                ctrl_q[i] <= '0;
                pc_q[i]   <= '0;
                rs1_q[i]  <= '0;
                rs2_q[i]  <= '0;
                imm_q[i]  <= '0;
            end
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of the others.
            state_q    <= state_d;
            id_ready_q <= id_ready_d;
            ctrl_q     <= ctrl_d;
            pc_q       <= pc_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            imm_q      <= imm_d;
        end
    end

    assign ex_alu_src = ctrl_q[0].alu_src;
    assign ex_alu_op  = ctrl_q[0].alu_op;
    assign ex_illegal = ctrl_q[0].illegal;
    assign ex_pc      = pc_q[0];
    assign ex_rs1     = rs1_q[0];
    assign ex_rs2     = rs2_q[0];
    assign ex_imm     = imm_q[0];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed cases plus random traffic against a queue model.
// Bypass cases are included when ALU_ISSUE_FWD_EN is defined.
module tb_alu_issue_ctrl;
    import my_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, id_valid, id_ready, id_funct7b5, ex_valid, ex_ready, ex_illegal;
    logic [6:0]  id_opcode;
    logic [2:0]  id_funct3, ex_alu_src;
    logic [3:0]  ex_alu_op;
    logic [31:0] id_pc, id_rs1, id_rs2, id_imm, ex_pc, ex_rs1, ex_rs2, ex_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, fwd_rd;
    logic        fwd_valid;
    logic [31:0] fwd_data;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
        .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_imm(id_imm),
`ifdef ALU_ISSUE_FWD_EN
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
`endif
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
        .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm),
        .ex_illegal(ex_illegal)
    );

    typedef struct {
        logic [31:0] pc, rs1, rs2, imm;
        logic [2:0]  src;
        logic [3:0]  op;
        logic        ill;
        logic [4:0]  a1, a2;
    } exp_t;

    exp_t q[$];
    bit   exp_ready;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] f3_op(input logic [2:0] f3, input logic b5, input bit is_reg);
        logic [3:0] r;
        if (f3 == 3'd0)      r = (is_reg && b5) ? 4'(ALU_SUB) : 4'(ALU_ADD);
        else if (f3 == 3'd1) r = 4'(ALU_SLL);
        else if (f3 == 3'd2) r = 4'(ALU_SLT);
        else if (f3 == 3'd3) r = 4'(ALU_SLTU);
        else if (f3 == 3'd4) r = 4'(ALU_XOR);
        else if (f3 == 3'd5) r = b5 ? 4'(ALU_SRA) : 4'(ALU_SRL);
        else if (f3 == 3'd6) r = 4'(ALU_OR);
        else                 r = 4'(ALU_AND);
        return r;
    endfunction

    // Reference decode taken straight from the opcode table, written with literal encodings.
    function automatic exp_t ref_decode();
        exp_t e;
        e.pc = id_pc; e.rs1 = id_rs1; e.rs2 = id_rs2; e.imm = id_imm;
        e.a1 = id_rs1_addr; e.a2 = id_rs2_addr;
        e.src = 3'b000; e.op = 4'(ALU_ADD); e.ill = 1'b0;
        if (id_opcode == 7'b0110011) e.op = f3_op(id_funct3, id_funct7b5, 1'b1);
        else if (id_opcode == 7'b0010011) begin
            e.src = 3'b010; e.op = f3_op(id_funct3, id_funct7b5, 1'b0);
        end
        else if (id_opcode == 7'b0000011 || id_opcode == 7'b0100011) e.src = 3'b010;
        else if (id_opcode == 7'b1100011) e.op = 4'(ALU_SUB);
        else if (id_opcode == 7'b0110111) begin
            e.src = 3'b010; e.rs1 = 32'd0; e.a1 = 5'd0;
        end
        else if (id_opcode == 7'b0010111) e.src = 3'b011;
        else if (id_opcode == 7'b1101111 || id_opcode == 7'b1100111) e.src = 3'b101;
        else e.ill = 1'b1;
        return e;
    endfunction

    function automatic exp_t apply_fwd(input exp_t e);
        exp_t r = e;
`ifdef ALU_ISSUE_FWD_EN
        if (fwd_valid && fwd_rd != 5'd0 && fwd_rd == e.a1) r.rs1 = fwd_data;
        if (fwd_valid && fwd_rd != 5'd0 && fwd_rd == e.a2) r.rs2 = fwd_data;
`endif
        return r;
    endfunction

    task automatic compare();
        check("ex_valid", 64'(ex_valid), 64'(q.size() != 0));
        check("id_ready", 64'(id_ready), 64'(exp_ready));
        if (q.size() != 0) begin
            check("ex_pc", 64'(ex_pc), 64'(q[0].pc));
            check("ex_rs1", 64'(ex_rs1), 64'(q[0].rs1));
            check("ex_rs2", 64'(ex_rs2), 64'(q[0].rs2));
            check("ex_imm", 64'(ex_imm), 64'(q[0].imm));
            check("ex_alu_src", 64'(ex_alu_src), 64'(q[0].src));
            check("ex_alu_op", 64'(ex_alu_op), 64'(q[0].op));
            check("ex_illegal", 64'(ex_illegal), 64'(q[0].ill));
        end
    endtask

    // Advance the model by the inputs now on the pins, cross one clock edge, then compare.
    task automatic tick();
        bit   acc, dep;
        exp_t n;
        acc = id_valid && exp_ready;
        dep = (q.size() != 0) && ex_ready;
        n   = apply_fwd(ref_decode());
        foreach (q[i]) q[i] = apply_fwd(q[i]);
        if (flush) q.delete();
        else begin
            if (dep) q.delete(0);
            if (acc) q.push_back(n);
        end
        exp_ready = (q.size() < 2);
        @(negedge clk);
        compare();
    endtask

    task automatic idle();
        id_valid = 1'b0; flush = 1'b0; fwd_valid = 1'b0;
    endtask

    task automatic offer(input logic [6:0] opc, input logic [2:0] f3, input logic b5,
                         input logic [31:0] pc, input logic [31:0] imm);
        id_valid = 1'b1; id_opcode = opc; id_funct3 = f3; id_funct7b5 = b5;
        id_pc = pc; id_imm = imm;
        id_rs1 = $urandom; id_rs2 = $urandom;
        id_rs1_addr = 5'($urandom_range(1, 31)); id_rs2_addr = 5'($urandom_range(1, 31));
    endtask

    logic [6:0] opc_tab [11];
    bit was_ready;

    initial begin
        opc_tab[0] = 7'b0110011; opc_tab[1] = 7'b0010011; opc_tab[2] = 7'b0000011;
        opc_tab[3] = 7'b0100011; opc_tab[4] = 7'b1100011; opc_tab[5] = 7'b0110111;
        opc_tab[6] = 7'b0010111; opc_tab[7] = 7'b1101111; opc_tab[8] = 7'b1100111;
        opc_tab[9] = 7'b0001111; opc_tab[10] = 7'b1110011;

        rst_n = 1'b0; ex_ready = 1'b0; fwd_rd = 5'd0; fwd_data = 32'd0;
        idle();
        offer(7'b0110011, 3'd0, 1'b0, 32'd0, 32'd0);
        id_valid = 1'b0;
        q.delete(); exp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_ex_valid", 64'(ex_valid), 64'd0);
        check("rst_id_ready", 64'(id_ready), 64'd1);
        check("rst_ex_pc", 64'(ex_pc), 64'd0);
        check("rst_ex_src", 64'(ex_alu_src), 64'd0);

        // AUIPC with a ready ALU: visible the next cycle.
        ex_ready = 1'b1;
        offer(7'b0010111, 3'd0, 1'b0, 32'h100, 32'h2000);
        tick();
        check("auipc_valid", 64'(ex_valid), 64'd1);
        check("auipc_src", 64'(ex_alu_src), 64'b011);
        check("auipc_op", 64'(ex_alu_op), 64'(ALU_ADD));
        check("auipc_pc", 64'(ex_pc), 64'h100);
        idle(); tick();

        // Back-pressure: three offers with the ALU stalled, then release.
        ex_ready = 1'b0;
        offer(7'b0110011, 3'd4, 1'b0, 32'hA00, 32'h1); tick();
        offer(7'b0000011, 3'd2, 1'b0, 32'hB00, 32'h2); tick();
        check("bp_ready_low", 64'(id_ready), 64'd0);
        offer(7'b1100011, 3'd1, 1'b0, 32'hC00, 32'h3); tick(); tick();
        check("bp_head_first", 64'(ex_pc), 64'hA00);
        ex_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            was_ready = exp_ready;
            tick();
            if (was_ready) id_valid = 1'b0;
        end
        check("bp_drained", 64'(ex_valid), 64'd0);

        // Flush beats a same-cycle accept.
        ex_ready = 1'b0;
        offer(7'b0110011, 3'd0, 1'b1, 32'hD00, 32'h4); tick();
        offer(7'b0010011, 3'd0, 1'b0, 32'hBAD0, 32'h5); flush = 1'b1; tick();
        check("flush_empty", 64'(ex_valid), 64'd0);
        check("flush_ready", 64'(id_ready), 64'd1);
        idle(); ex_ready = 1'b1;
        offer(7'b1101111, 3'd0, 1'b0, 32'hF00, 32'h6); tick();
        check("flush_drop", 64'(ex_pc), 64'hF00);
        idle(); tick();

        // SRA and an illegal opcode.
        offer(7'b0110011, 3'd5, 1'b1, 32'h200, 32'h7); tick();
        check("sra_op", 64'(ex_alu_op), 64'(ALU_SRA));
        check("sra_src", 64'(ex_alu_src), 64'b000);
        offer(7'b0001111, 3'd0, 1'b0, 32'h204, 32'h8); tick();
        check("illegal_flag", 64'(ex_illegal), 64'd1);
        check("illegal_src", 64'(ex_alu_src), 64'b000);
        idle(); tick();

`ifdef ALU_ISSUE_FWD_EN
        ex_ready = 1'b0;
        offer(7'b0110011, 3'd0, 1'b0, 32'h300, 32'h9);
        id_rs1_addr = 5'd5; id_rs2_addr = 5'd6; id_rs1 = 32'h1111;
        tick(); idle();
        fwd_valid = 1'b1; fwd_rd = 5'd5; fwd_data = 32'hDEAD; tick();
        check("fwd_rs1", 64'(ex_rs1), 64'hDEAD);
        fwd_rd = 5'd0; fwd_data = 32'hBEEF; tick();
        check("fwd_rd0", 64'(ex_rs1), 64'hDEAD);
        idle(); ex_ready = 1'b1; tick();
`endif

        // Asynchronous reset while two entries are buffered.
        ex_ready = 1'b0;
        offer(7'b0010011, 3'd1, 1'b0, 32'h400, 32'hA); tick();
        offer(7'b0100011, 3'd2, 1'b0, 32'h404, 32'hB); tick();
        idle();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(ex_valid), 64'd0);
        check("mid_rst_ready", 64'(id_ready), 64'd1);
        check("mid_rst_pc", 64'(ex_pc), 64'd0);
        check("mid_rst_imm", 64'(ex_imm), 64'd0);
        q.delete(); exp_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            offer(opc_tab[$urandom_range(0, 10)], 3'($urandom), 1'($urandom), $urandom, $urandom);
            if (c % 97 == 0) id_opcode = 7'($urandom);
            id_valid  = ($urandom_range(0, 2) != 0);
            ex_ready  = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            fwd_valid = 1'($urandom);
            fwd_rd    = 5'($urandom_range(0, 7));
            fwd_data  = $urandom;
            id_rs1_addr = 5'($urandom_range(0, 7));
            id_rs2_addr = 5'($urandom_range(0, 7));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
